alu_operand_stage: RTL

//  ID/EX pipeline register directly upstream of the ALU. Captures decoded operands,

---
 rtl/alu_operand_stage.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// ID/EX operand register in front of the ALU: captures decoded operands, forwards
// from EX/MEM and MEM/WB, selects ALU inputs and enforces the load-use interlock.
package risc_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;
endpackage

module alu_operand_stage
  import risc_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RA_W    = 5,
  parameter int STALL_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RA_W-1:0]     in_rs1_addr,
  input  logic [RA_W-1:0]     in_rs2_addr,
  input  logic [XLEN-1:0]     in_rs1_val,
  input  logic [XLEN-1:0]     in_rs2_val,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [XLEN-1:0]     in_imm,
  input  logic                in_a_sel_pc,
  input  logic                in_b_sel_imm,
  input  alu_op_t             in_alu_op,
  input  logic                exm_wen,
  input  logic                exm_is_load,
  input  logic [RA_W-1:0]     exm_rd,
  input  logic [XLEN-1:0]     exm_data,
  input  logic                wb_wen,
  input  logic [RA_W-1:0]     wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     alu_a,
  output logic [XLEN-1:0]     alu_b,
  output alu_op_t             alu_op,
  output logic [XLEN-1:0]     rs2_fwd,
  output logic [STALL_W-1:0]  stall_cnt
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // Valid never depends on ready on either side; in_ready depends on out_ready only
  // through the single-entry register draining this cycle.

  logic                held_valid;
  logic [RA_W-1:0]     rs1_addr_q, rs2_addr_q;
  logic [XLEN-1:0]     rs1_val_q, rs2_val_q, pc_q, imm_q;
  logic                a_sel_pc_q, b_sel_imm_q;
  alu_op_t             alu_op_q;
  logic [STALL_W-1:0]  stall_cnt_q;

  logic [XLEN-1:0]     rs1_fwd;
  logic                load_use;
  logic                capture;
  logic                drain;

  // x0 is hard zero and never takes a forwarded value.
  always_comb begin
    rs1_fwd = rs1_val_q;
    if (rs1_addr_q == '0)
      rs1_fwd = '0;
    else if (exm_wen && exm_rd == rs1_addr_q)
      rs1_fwd = exm_data;
    else if (wb_wen && wb_rd == rs1_addr_q)
      rs1_fwd = wb_data;
  end

  always_comb begin
    rs2_fwd = rs2_val_q;
    if (rs2_addr_q == '0)
      rs2_fwd = '0;
    else if (exm_wen && exm_rd == rs2_addr_q)
      rs2_fwd = exm_data;
    else if (wb_wen && wb_rd == rs2_addr_q)
      rs2_fwd = wb_data;
  end

  // rs2 is always considered used because stores need it as data.
  always_comb begin
    load_use = 1'b0;
    if (held_valid && exm_is_load && exm_wen) begin
      if (!a_sel_pc_q && rs1_addr_q != '0 && exm_rd == rs1_addr_q)
        load_use = 1'b1;
      if (rs2_addr_q != '0 && exm_rd == rs2_addr_q)
        load_use = 1'b1;
    end
  end

  assign out_valid = held_valid & ~load_use;
  assign drain     = out_valid & out_ready;
  assign in_ready  = ~held_valid | drain;
  assign capture   = in_valid & in_ready & ~flush;

  assign alu_a     = a_sel_pc_q  ? pc_q  : rs1_fwd;
  assign alu_b     = b_sel_imm_q ? imm_q : rs2_fwd;
  assign alu_op    = alu_op_q;
  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_valid <= 1'b0;
    end else if (flush) begin
      held_valid <= 1'b0;
    end else if (capture) begin
      held_valid <= 1'b1;
    end else if (drain) begin
      held_valid <= 1'b0;
    end
  end

  // A WB write landing on the capture edge or while holding must be kept,
  // since the forwarding path disappears once WB retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      a_sel_pc_q  <= 1'b0;
      b_sel_imm_q <= 1'b0;
      alu_op_q    <= ALU_ADD;
    end else if (capture) begin
      rs1_addr_q  <= in_rs1_addr;
      rs2_addr_q  <= in_rs2_addr;
      rs1_val_q   <= (wb_wen && wb_rd == in_rs1_addr && in_rs1_addr != '0) ? wb_data : in_rs1_val;
      rs2_val_q   <= (wb_wen && wb_rd == in_rs2_addr && in_rs2_addr != '0) ? wb_data : in_rs2_val;
      pc_q        <= in_pc;
      imm_q       <= in_imm;
      a_sel_pc_q  <= in_a_sel_pc;
      b_sel_imm_q <= in_b_sel_imm;
      alu_op_q    <= in_alu_op;
    end else if (held_valid && wb_wen) begin
      if (wb_rd == rs1_addr_q && rs1_addr_q != '0) rs1_val_q <= wb_data;
      if (wb_rd == rs2_addr_q && rs2_addr_q != '0) rs2_val_q <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (held_valid && !drain && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule
